// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, 1-cycle-early pixel request, registered syncs/DE/colour.
// Optional colour-bar test pattern (adds i_PATTERN) when VGA_TIMING_GEN_PATTERN_EN is defined.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int COLOR_BITS = 4,
   parameter int CNT_W      = 12
) (
   input  logic                    i_CLK,
   input  logic                    i_RESET,
   input  logic [3*COLOR_BITS-1:0] i_RGB,
`ifdef VGA_TIMING_GEN_PATTERN_EN
   input  logic                    i_PATTERN,
`endif
   output logic                    o_REQ,
   output logic [CNT_W-1:0]        o_X,
   output logic [CNT_W-1:0]        o_Y,
   output logic                    o_HSYNC,
   output logic                    o_VSYNC,
   output logic                    o_DE,
   output logic [COLOR_BITS-1:0]   o_RED,
   output logic [COLOR_BITS-1:0]   o_GREEN,
   output logic [COLOR_BITS-1:0]   o_BLUE,
   output logic                    o_FRAME_START,
   output logic                    o_LINE_END
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_HS_START = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] H_HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_VS_START = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] V_VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

   // Strict bound keeps the sync-end compare values representable too.
   generate
      if (longint'(H_TOTAL) >= (longint'(1) << CNT_W) ||
          longint'(V_TOTAL) >= (longint'(1) << CNT_W)) begin : g_size_check
         $error("vga_timing_gen: H/V totals do not fit in CNT_W bits");
      end
   endgenerate

   logic [CNT_W-1:0]        h_cnt_reg, v_cnt_reg;
   logic                    active, hs, vs;
   logic                    req_reg, line_end_reg, frame_start_reg, hs_reg, vs_reg;
   logic [CNT_W-1:0]        x_reg, y_reg;
   logic                    de_reg, hsync_reg, vsync_reg;
   logic [3*COLOR_BITS-1:0] pix, rgb_reg;

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else if (h_cnt_reg == H_LAST) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + CNT_W'(1);
      end else begin
         h_cnt_reg <= h_cnt_reg + CNT_W'(1);
      end
   end

   always_comb begin
      active = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
      hs     = (h_cnt_reg >= H_HS_START) && (h_cnt_reg < H_HS_END);
      vs     = (v_cnt_reg >= V_VS_START) && (v_cnt_reg < V_VS_END);
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         req_reg         <= 1'b0;
         x_reg           <= '0;
         y_reg           <= '0;
         line_end_reg    <= 1'b0;
         frame_start_reg <= 1'b0;
         hs_reg          <= 1'b0;
         vs_reg          <= 1'b0;
      end else begin
         req_reg         <= active;
         x_reg           <= h_cnt_reg;
         y_reg           <= v_cnt_reg;
         line_end_reg    <= (h_cnt_reg == H_LAST);
         frame_start_reg <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
         hs_reg          <= hs;
         vs_reg          <= vs;
      end
   end

`ifdef VGA_TIMING_GEN_PATTERN_EN
   logic [CNT_W+2:0]        x_times8;
   logic [2:0]              bar_idx;
   logic [3*COLOR_BITS-1:0] bar_rgb;

   // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
   always_comb begin
      x_times8 = {x_reg, 3'b000};
      bar_idx  = '0;
      for (int k = 1; k < 8; k++) begin
         if (x_times8 >= (CNT_W+3)'(k * H_ACTIVE)) bar_idx = 3'(k);
      end
      bar_rgb = {{COLOR_BITS{~bar_idx[1]}}, {COLOR_BITS{~bar_idx[2]}}, {COLOR_BITS{~bar_idx[0]}}};
   end

   always_comb begin
      pix = i_PATTERN ? bar_rgb : i_RGB;
   end
`else
   always_comb begin
      pix = i_RGB;
   end
`endif

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         de_reg    <= 1'b0;
         hsync_reg <= ~H_SYNC_POL;
         vsync_reg <= ~V_SYNC_POL;
         rgb_reg   <= '0;
      end else begin
         de_reg    <= req_reg;
         hsync_reg <= hs_reg ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_reg <= vs_reg ? V_SYNC_POL : ~V_SYNC_POL;
         rgb_reg   <= req_reg ? pix : '0;
      end
   end

   assign o_REQ         = req_reg;
   assign o_X           = x_reg;
   assign o_Y           = y_reg;
   assign o_LINE_END    = line_end_reg;
   assign o_FRAME_START = frame_start_reg;
   assign o_DE          = de_reg;
   assign o_HSYNC       = hsync_reg;
   assign o_VSYNC       = vsync_reg;
   assign o_RED         = rgb_reg[3*COLOR_BITS-1 -: COLOR_BITS];
   assign o_GREEN       = rgb_reg[2*COLOR_BITS-1 -: COLOR_BITS];
   assign o_BLUE        = rgb_reg[COLOR_BITS-1 -: COLOR_BITS];

endmodule
